// File: rtl/vx_hpdcache_mem_bridge.sv
// Bridge between the VX line-request port and the HPDcache memory interface.
// Requests are tagged with a memory ID taken from a small table of in-flight
// entries; read responses are translated back to the original VX tag.
module vx_hpdcache_mem_bridge #(
    parameter int ADDR_WIDTH      = 26,
    parameter int DATA_WIDTH      = 512,
    parameter int TAG_WIDTH       = 8,
    parameter int ID_WIDTH        = 4,
    parameter int NUM_OUTSTANDING = 8,
    localparam int BYTES          = DATA_WIDTH / 8,
    localparam int OFFSET_WIDTH   = $clog2(BYTES),
    localparam int MEM_ADDR_WIDTH = ADDR_WIDTH + OFFSET_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      vx_req_valid,
    output logic                      vx_req_ready,
    input  logic                      vx_req_rw,
    input  logic [ADDR_WIDTH-1:0]     vx_req_addr,
    input  logic [DATA_WIDTH-1:0]     vx_req_data,
    input  logic [BYTES-1:0]          vx_req_byteen,
    input  logic [TAG_WIDTH-1:0]      vx_req_tag,

    output logic                      vx_rsp_valid,
    input  logic                      vx_rsp_ready,
    output logic [DATA_WIDTH-1:0]     vx_rsp_data,
    output logic [TAG_WIDTH-1:0]      vx_rsp_tag,

    output logic                      mem_req_read_valid,
    input  logic                      mem_req_read_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_read_addr,
    output logic [ID_WIDTH-1:0]       mem_req_read_id,

    output logic                      mem_req_write_valid,
    input  logic                      mem_req_write_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_write_addr,
    output logic [ID_WIDTH-1:0]       mem_req_write_id,

    output logic                      mem_req_write_data_valid,
    input  logic                      mem_req_write_data_ready,
    output logic [DATA_WIDTH-1:0]     mem_req_write_data,
    output logic [BYTES-1:0]          mem_req_write_be,

    input  logic                      mem_resp_read_valid,
    output logic                      mem_resp_read_ready,
    input  logic [ID_WIDTH-1:0]       mem_resp_read_id,
    input  logic [DATA_WIDTH-1:0]     mem_resp_read_data,

    input  logic                      mem_resp_write_valid,
    output logic                      mem_resp_write_ready,
    input  logic [ID_WIDTH-1:0]       mem_resp_write_id,

    output logic                      err
);

    // ID table
    logic [NUM_OUTSTANDING-1:0] busy_q, busy_d;
    logic [NUM_OUTSTANDING-1:0] is_write_q;
    logic [TAG_WIDTH-1:0]       tag_q [NUM_OUTSTANDING];

    // Issue stage: one pending flag per outgoing channel
    logic                      rd_pend_q, wa_pend_q, wd_pend_q;
    logic [MEM_ADDR_WIDTH-1:0] iss_addr_q;
    logic [ID_WIDTH-1:0]       iss_id_q;
    logic [DATA_WIDTH-1:0]     iss_data_q;
    logic [BYTES-1:0]          iss_be_q;

    // Read-response output stage
    logic                      rsp_valid_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic [TAG_WIDTH-1:0]      rsp_tag_q;

    logic                      err_q;

    logic                       free_found;
    logic [ID_WIDTH-1:0]        alloc_idx;
    logic                       stage_clear;
    logic                       vx_accept;
    logic [NUM_OUTSTANDING-1:0] alloc_vec;
    logic [NUM_OUTSTANDING-1:0] rd_hit_vec, wr_hit_vec, free_vec;
    logic [TAG_WIDTH-1:0]       rsp_tag_sel;
    logic                       rd_resp_fire, rd_resp_ok, wr_resp_ok;

    // Lowest-index free entry; scanning downward leaves the lowest hit last
    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        for (int i = NUM_OUTSTANDING - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                alloc_idx  = ID_WIDTH'(i);
            end
        end
    end

    // A new request may enter only if every pending channel drains this cycle
    assign stage_clear = (!rd_pend_q || mem_req_read_ready) &&
                         (!wa_pend_q || mem_req_write_ready) &&
                         (!wd_pend_q || mem_req_write_data_ready);
    assign vx_req_ready = free_found && stage_clear;
    assign vx_accept    = vx_req_valid && vx_req_ready;

    // Decode response IDs against the table; out-of-range IDs never hit
    always_comb begin
        rd_hit_vec  = '0;
        wr_hit_vec  = '0;
        alloc_vec   = '0;
        rsp_tag_sel = '0;
        for (int i = 0; i < NUM_OUTSTANDING; i++) begin
            if (mem_resp_read_id == ID_WIDTH'(i)) begin
                rd_hit_vec[i] = busy_q[i] && !is_write_q[i];
                rsp_tag_sel   = tag_q[i];
            end
            if (mem_resp_write_id == ID_WIDTH'(i)) begin
                wr_hit_vec[i] = busy_q[i] && is_write_q[i];
            end
            alloc_vec[i] = vx_accept && (alloc_idx == ID_WIDTH'(i));
        end
    end

    assign mem_resp_read_ready  = !rsp_valid_q || vx_rsp_ready;
    assign mem_resp_write_ready = 1'b1;
    assign rd_resp_fire         = mem_resp_read_valid && mem_resp_read_ready;
    assign rd_resp_ok           = |rd_hit_vec;
    assign wr_resp_ok           = |wr_hit_vec;

    // Frees come from the current table, so a freed slot is allocatable next cycle
    always_comb begin
        free_vec = '0;
        if (rd_resp_fire) free_vec = free_vec | rd_hit_vec;
        if (mem_resp_write_valid) free_vec = free_vec | wr_hit_vec;
        busy_d = (busy_q & ~free_vec) | alloc_vec;
    end

    // Table state: busy flags, access kind and original tag
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            is_write_q <= '0;
            for (int i = 0; i < NUM_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NUM_OUTSTANDING; i++) begin
                if (alloc_vec[i]) begin
                    is_write_q[i] <= vx_req_rw;
                    tag_q[i]      <= vx_req_tag;
                end
            end
        end
    end

    // Issue-stage channel flags; each write channel clears on its own handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            wa_pend_q <= 1'b0;
            wd_pend_q <= 1'b0;
        end else if (vx_accept) begin
            rd_pend_q <= !vx_req_rw;
            wa_pend_q <= vx_req_rw;
            wd_pend_q <= vx_req_rw;
        end else begin
            if (mem_req_read_ready)       rd_pend_q <= 1'b0;
            if (mem_req_write_ready)      wa_pend_q <= 1'b0;
            if (mem_req_write_data_ready) wd_pend_q <= 1'b0;
        end
    end

    // Issue-stage payload, loaded only on accept so it is stable while stalled
    always_ff @(posedge clk) begin
        if (vx_accept) begin
            iss_addr_q <= {vx_req_addr, {OFFSET_WIDTH{1'b0}}};
            iss_id_q   <= alloc_idx;
            iss_data_q <= vx_req_data;
            iss_be_q   <= vx_req_byteen;
        end
    end

    assign mem_req_read_valid       = rd_pend_q;
    assign mem_req_read_addr        = iss_addr_q;
    assign mem_req_read_id          = iss_id_q;
    assign mem_req_write_valid      = wa_pend_q;
    assign mem_req_write_addr       = iss_addr_q;
    assign mem_req_write_id         = iss_id_q;
    assign mem_req_write_data_valid = wd_pend_q;
    assign mem_req_write_data       = iss_data_q;
    assign mem_req_write_be         = iss_be_q;

    // Output-stage valid: load on a legal read response, clear on VX handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
        end else if (rd_resp_fire && rd_resp_ok) begin
            rsp_valid_q <= 1'b1;
        end else if (vx_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Output-stage payload
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else if (rd_resp_fire && rd_resp_ok) begin
            rsp_data_q <= mem_resp_read_data;
            rsp_tag_q  <= rsp_tag_sel;
        end
    end

    assign vx_rsp_valid = rsp_valid_q;
    assign vx_rsp_data  = rsp_data_q;
    assign vx_rsp_tag   = rsp_tag_q;

    // Sticky error on any response that does not match a busy entry of its kind
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((rd_resp_fire && !rd_resp_ok) ||
                     (mem_resp_write_valid && !wr_resp_ok)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_vx_hpdcache_mem_bridge.sv
// Scoreboard bench for vx_hpdcache_mem_bridge: stimulus pushes expected
// transactions, negedge monitors pop and compare on each handshake.
module tb_vx_hpdcache_mem_bridge;

    localparam int AW  = 26;
    localparam int DW  = 512;
    localparam int TW  = 8;
    localparam int IW  = 4;
    localparam int NO  = 8;
    localparam int BY  = DW / 8;
    localparam int MAW = AW + 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            vx_req_valid, vx_req_ready, vx_req_rw;
    logic [AW-1:0]   vx_req_addr;
    logic [DW-1:0]   vx_req_data;
    logic [BY-1:0]   vx_req_byteen;
    logic [TW-1:0]   vx_req_tag;
    logic            vx_rsp_valid, vx_rsp_ready;
    logic [DW-1:0]   vx_rsp_data;
    logic [TW-1:0]   vx_rsp_tag;
    logic            mem_req_read_valid, mem_req_read_ready;
    logic [MAW-1:0]  mem_req_read_addr;
    logic [IW-1:0]   mem_req_read_id;
    logic            mem_req_write_valid, mem_req_write_ready;
    logic [MAW-1:0]  mem_req_write_addr;
    logic [IW-1:0]   mem_req_write_id;
    logic            mem_req_write_data_valid, mem_req_write_data_ready;
    logic [DW-1:0]   mem_req_write_data;
    logic [BY-1:0]   mem_req_write_be;
    logic            mem_resp_read_valid, mem_resp_read_ready;
    logic [IW-1:0]   mem_resp_read_id;
    logic [DW-1:0]   mem_resp_read_data;
    logic            mem_resp_write_valid, mem_resp_write_ready;
    logic [IW-1:0]   mem_resp_write_id;
    logic            err;

    vx_hpdcache_mem_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
        .ID_WIDTH(IW), .NUM_OUTSTANDING(NO)
    ) dut (
        .clk(clk), .reset(reset),
        .vx_req_valid(vx_req_valid), .vx_req_ready(vx_req_ready),
        .vx_req_rw(vx_req_rw), .vx_req_addr(vx_req_addr),
        .vx_req_data(vx_req_data), .vx_req_byteen(vx_req_byteen),
        .vx_req_tag(vx_req_tag),
        .vx_rsp_valid(vx_rsp_valid), .vx_rsp_ready(vx_rsp_ready),
        .vx_rsp_data(vx_rsp_data), .vx_rsp_tag(vx_rsp_tag),
        .mem_req_read_valid(mem_req_read_valid), .mem_req_read_ready(mem_req_read_ready),
        .mem_req_read_addr(mem_req_read_addr), .mem_req_read_id(mem_req_read_id),
        .mem_req_write_valid(mem_req_write_valid), .mem_req_write_ready(mem_req_write_ready),
        .mem_req_write_addr(mem_req_write_addr), .mem_req_write_id(mem_req_write_id),
        .mem_req_write_data_valid(mem_req_write_data_valid),
        .mem_req_write_data_ready(mem_req_write_data_ready),
        .mem_req_write_data(mem_req_write_data), .mem_req_write_be(mem_req_write_be),
        .mem_resp_read_valid(mem_resp_read_valid), .mem_resp_read_ready(mem_resp_read_ready),
        .mem_resp_read_id(mem_resp_read_id), .mem_resp_read_data(mem_resp_read_data),
        .mem_resp_write_valid(mem_resp_write_valid), .mem_resp_write_ready(mem_resp_write_ready),
        .mem_resp_write_id(mem_resp_write_id),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [MAW-1:0] addr; logic [IW-1:0] id; } req_t;
    typedef struct packed { logic [DW-1:0] data; logic [BY-1:0] be; } wd_t;
    typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; } rsp_t;

    req_t exp_rd_q[$];
    req_t exp_wa_q[$];
    wd_t  exp_wd_q[$];
    rsp_t exp_rsp_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no/unexpected event, expected a matching handshake", name);
    endtask

    function automatic logic [DW-1:0] mkd(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {16{w}};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vx_send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BY-1:0] be, input logic [TW-1:0] tag);
        bit ok = 1'b0;
        vx_req_valid = 1'b1; vx_req_rw = rw; vx_req_addr = a;
        vx_req_data = d; vx_req_byteen = be; vx_req_tag = tag;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (vx_req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        vx_req_valid = 1'b0;
        if (!ok) note_fail("vx_req_timeout");
    endtask

    task automatic mem_rd_resp(input logic [IW-1:0] id, input logic [DW-1:0] d);
        bit ok = 1'b0;
        mem_resp_read_valid = 1'b1; mem_resp_read_id = id; mem_resp_read_data = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_resp_read_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        mem_resp_read_valid = 1'b0;
        if (!ok) note_fail("mem_resp_read_timeout");
    endtask

    task automatic mem_wr_resp(input logic [IW-1:0] id);
        mem_resp_write_valid = 1'b1; mem_resp_write_id = id;
        @(posedge clk); #1;
        mem_resp_write_valid = 1'b0;
    endtask

    // Monitors: handshakes seen at negedge complete at the following posedge
    always @(negedge clk) begin
        req_t r;
        if (!reset && mem_req_read_valid && mem_req_read_ready) begin
            if (exp_rd_q.size() == 0) note_fail("rd_req_unexpected");
            else begin
                r = exp_rd_q.pop_front();
                chk("rd_req_addr", DW'(mem_req_read_addr), DW'(r.addr));
                chk("rd_req_id", DW'(mem_req_read_id), DW'(r.id));
            end
        end
    end

    always @(negedge clk) begin
        req_t r;
        if (!reset && mem_req_write_valid && mem_req_write_ready) begin
            if (exp_wa_q.size() == 0) note_fail("wr_req_unexpected");
            else begin
                r = exp_wa_q.pop_front();
                chk("wr_req_addr", DW'(mem_req_write_addr), DW'(r.addr));
                chk("wr_req_id", DW'(mem_req_write_id), DW'(r.id));
            end
        end
    end

    always @(negedge clk) begin
        wd_t w;
        if (!reset && mem_req_write_data_valid && mem_req_write_data_ready) begin
            if (exp_wd_q.size() == 0) note_fail("wr_data_unexpected");
            else begin
                w = exp_wd_q.pop_front();
                chk("wr_data", mem_req_write_data, w.data);
                chk("wr_be", DW'(mem_req_write_be), DW'(w.be));
            end
        end
    end

    always @(negedge clk) begin
        rsp_t s;
        if (!reset && vx_rsp_valid && vx_rsp_ready) begin
            if (exp_rsp_q.size() == 0) note_fail("vx_rsp_unexpected");
            else begin
                s = exp_rsp_q.pop_front();
                chk("vx_rsp_tag", DW'(vx_rsp_tag), DW'(s.tag));
                chk("vx_rsp_data", vx_rsp_data, s.data);
            end
        end
    end

    // Stalled write channels must hold valid and payload
    logic           wa_stall = 1'b0, wd_stall = 1'b0;
    logic [MAW-1:0] wa_prev;
    logic [DW-1:0]  wd_prev;
    always @(negedge clk) begin
        if (!reset && wa_stall)
            chk("wa_hold", DW'({mem_req_write_valid, mem_req_write_addr}), DW'({1'b1, wa_prev}));
        if (!reset && wd_stall)
            chk("wd_hold", {mem_req_write_data_valid, mem_req_write_data[DW-2:0]},
                {1'b1, wd_prev[DW-2:0]});
        wa_stall = !reset && mem_req_write_valid && !mem_req_write_ready;
        wd_stall = !reset && mem_req_write_data_valid && !mem_req_write_data_ready;
        wa_prev  = mem_req_write_addr;
        wd_prev  = mem_req_write_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    localparam logic [DW-1:0] D_A  = {16{32'hA5A5_0001}};
    localparam logic [DW-1:0] D_W  = {16{32'h1234_5678}};
    localparam logic [BY-1:0] BE_W = {8{8'h0F}};

    initial begin
        vx_req_valid = 0; vx_req_rw = 0; vx_req_addr = '0; vx_req_data = '0;
        vx_req_byteen = '0; vx_req_tag = '0; vx_rsp_ready = 0;
        mem_req_read_ready = 0; mem_req_write_ready = 0; mem_req_write_data_ready = 0;
        mem_resp_read_valid = 0; mem_resp_read_id = '0; mem_resp_read_data = '0;
        mem_resp_write_valid = 0; mem_resp_write_id = '0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_ready", DW'(vx_req_ready), DW'(1));
        chk("rst_valids", DW'({mem_req_read_valid, mem_req_write_valid,
                               mem_req_write_data_valid, vx_rsp_valid}), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("wr_resp_ready", DW'(mem_resp_write_ready), DW'(1));

        // Single read, tag 0x5A at line 0x100
        mem_req_read_ready = 1; vx_rsp_ready = 1;
        exp_rd_q.push_back({32'h0000_4000, 4'd0});
        vx_send(1'b0, 26'h100, '0, '1, 8'h5A);
        tick(2);
        exp_rsp_q.push_back({8'h5A, D_A});
        mem_rd_resp(4'd0, D_A);
        chk("rsp_latency", DW'(vx_rsp_valid), DW'(1));
        tick(2);
        chk("rsp_drained", DW'(vx_rsp_valid), DW'(0));

        // Write: data channel completes 2 cycles before address channel
        exp_wa_q.push_back({32'h0000_0800, 4'd0});
        exp_wd_q.push_back({D_W, BE_W});
        vx_send(1'b1, 26'h20, D_W, BE_W, 8'h11);
        chk("wr_stage_busy_ready", DW'(vx_req_ready), DW'(0));
        chk("wr_valids", DW'({mem_req_write_valid, mem_req_write_data_valid, mem_req_read_valid}),
            DW'(3'b110));
        mem_req_write_data_ready = 1; tick(1); mem_req_write_data_ready = 0;
        chk("wd_dropped_first", DW'({mem_req_write_valid, mem_req_write_data_valid}), DW'(2'b10));
        tick(1);
        mem_req_write_ready = 1; tick(1); mem_req_write_ready = 0;
        chk("wr_stage_empty", DW'({mem_req_write_valid, mem_req_write_data_valid}), DW'(0));
        chk("wr_done_ready", DW'(vx_req_ready), DW'(1));
        tick(2);
        mem_wr_resp(4'd0);
        chk("wr_resp_no_err", DW'(err), DW'(0));
        tick(2);
        chk("wr_no_rsp", DW'(vx_rsp_valid), DW'(0));

        // Fill all 8 entries with reads; entry 0 must be free again after the write
        for (int i = 0; i < 8; i++) begin
            exp_rd_q.push_back({32'h0000_8000 + 32'(i * 64), IW'(i)});
            vx_send(1'b0, AW'(32'h200 + i), '0, '1, TW'(8'h80 + i));
        end
        tick(2);
        chk("full_ready", DW'(vx_req_ready), DW'(0));
        exp_rsp_q.push_back({8'h83, mkd(3)});
        mem_rd_resp(4'd3, mkd(3));
        chk("ready_after_free", DW'(vx_req_ready), DW'(1));
        exp_rd_q.push_back({32'h0000_C000, 4'd3});
        vx_send(1'b0, 26'h300, '0, '1, 8'h99);
        tick(2);
        chk("full_again", DW'(vx_req_ready), DW'(0));

        // Output back-pressure with two responses pending
        vx_rsp_ready = 0;
        exp_rsp_q.push_back({8'h80, mkd(0)});
        exp_rsp_q.push_back({8'h81, mkd(1)});
        mem_rd_resp(4'd0, mkd(0));
        chk("held_valid", DW'(vx_rsp_valid), DW'(1));
        mem_resp_read_valid = 1; mem_resp_read_id = 4'd1; mem_resp_read_data = mkd(1);
        tick(3);
        chk("resp_backpressure", DW'(mem_resp_read_ready), DW'(0));
        chk("held_tag", DW'(vx_rsp_tag), DW'(8'h80));
        chk("held_data", vx_rsp_data, mkd(0));
        vx_rsp_ready = 1;
        mem_rd_resp(4'd1, mkd(1));

        // Drain the rest, including the reallocated entry 3
        for (int i = 2; i < 8; i++) begin
            if (i != 3) begin
                exp_rsp_q.push_back({TW'(8'h80 + i), mkd(i)});
                mem_rd_resp(IW'(i), mkd(i));
            end
        end
        exp_rsp_q.push_back({8'h99, mkd(33)});
        mem_rd_resp(4'd3, mkd(33));
        tick(3);
        chk("drained_ready", DW'(vx_req_ready), DW'(1));
        chk("drained_err", DW'(err), DW'(0));

        // Stray write response sets sticky err
        mem_wr_resp(4'd5);
        chk("stray_wr_err", DW'(err), DW'(1));
        tick(5);
        chk("err_sticky", DW'(err), DW'(1));

        // Reset with 3 outstanding reads, then a stale response
        reset = 1; tick(2); reset = 0; tick(1);
        chk("reset_clears_err", DW'(err), DW'(0));
        for (int i = 0; i < 3; i++) begin
            exp_rd_q.push_back({32'h0001_0000 + 32'(i * 64), IW'(i)});
            vx_send(1'b0, AW'(32'h400 + i), '0, '1, TW'(8'h40 + i));
        end
        tick(3);
        reset = 1; tick(2); reset = 0; tick(1);
        chk("midrst_ready", DW'(vx_req_ready), DW'(1));
        chk("midrst_valids", DW'({mem_req_read_valid, mem_req_write_valid,
                                  mem_req_write_data_valid, vx_rsp_valid}), DW'(0));
        exp_rd_q.push_back({32'h0000_1000, 4'd0});
        vx_send(1'b0, 26'h40, '0, '1, 8'h77);
        tick(2);
        mem_rd_resp(4'd1, mkd(99));
        chk("stale_rd_err", DW'(err), DW'(1));
        tick(2);
        chk("stale_no_rsp", DW'(vx_rsp_valid), DW'(0));

        tick(3);
        chk("rd_q_empty", DW'(exp_rd_q.size()), DW'(0));
        chk("wa_q_empty", DW'(exp_wa_q.size()), DW'(0));
        chk("wd_q_empty", DW'(exp_wd_q.size()), DW'(0));
        chk("rsp_q_empty", DW'(exp_rsp_q.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
